// File: rtl/scc_8lc_pkg.sv
// Shared SCC 8LC definitions: decoder error codes and their RAS classification.
package scc_8lc_pkg;

    localparam int MSG_W = 64;

    typedef enum logic [2:0] {
        ET_NONE    = 3'd0,
        ET_SE      = 3'd1,
        ET_DE_DAE  = 3'd2,
        ET_DE_NDAE = 3'd3,
        ET_TE      = 3'd4
    } err_type_e;

    function automatic logic is_corrected(input logic [2:0] et);
        return (et >= 3'(ET_SE)) && (et <= 3'(ET_TE));
    endfunction

    // Every code above the last correctable one is reported as uncorrectable.
    function automatic logic is_due(input logic [2:0] et);
        return et > 3'(ET_TE);
    endfunction

endpackage

// File: rtl/scc_8lc_scrub_fifo.sv
// Synchronous scrub-request FIFO; a push while full is taken only when a pop frees a slot.
module scc_8lc_scrub_fifo
    import scc_8lc_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/scc_8lc_read_resp_stage.sv
// Registered read-response stage behind the SCC 8LC decoder: skid-buffered data path,
// scrub request queue for corrected lines and saturating RAS error counters.
module scc_8lc_read_resp_stage
    import scc_8lc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int SCRUB_DEPTH = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [MSG_W-1:0]  in_message,
    input  logic [2:0]        in_error_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [MSG_W-1:0]  out_data,
    output logic              out_corrected,
    output logic              out_poison,
    output logic              scrub_valid,
    input  logic              scrub_ready,
    output logic [ADDR_W-1:0] scrub_addr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  due_count,
    output logic [CNT_W-1:0]  scrub_drop
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              accept;
    logic              out_pop;
    logic              load_main;
    logic              in_corr;
    logic              in_due;

    logic              skid_vld_p0;
    logic [ADDR_W-1:0] skid_addr_p0;
    logic [MSG_W-1:0]  skid_data_p0;
    logic              skid_corr_p0;
    logic              skid_due_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [MSG_W-1:0]  data_p1;
    logic              corr_p1;
    logic              due_p1;

    logic              scrub_push;
    logic              scrub_full;
    logic              scrub_empty;
    logic              scrub_dropped;

    assign in_ready  = !skid_vld_p0;
    assign accept    = in_valid && in_ready;
    assign out_pop   = vld_p1 && out_ready;
    assign load_main = out_pop || !vld_p1;
    assign in_corr   = is_corrected(in_error_type);
    assign in_due    = is_due(in_error_type);

    // Stage p0: skid entry catches a beat only while the main entry is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld_p0 <= 1'b0;
        end else if (load_main) begin
            skid_vld_p0 <= 1'b0;
        end else if (accept) begin
            skid_vld_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!load_main && accept) begin
            skid_addr_p0 <= in_addr;
            skid_data_p0 <= in_message;
            skid_corr_p0 <= in_corr;
            skid_due_p0  <= in_due;
        end
    end

    // Stage p1: main entry drives out_*; the skid entry is older, so it refills first.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (load_main) begin
            vld_p1 <= skid_vld_p0 || accept;
        end
    end

    always_ff @(posedge clk) begin
        if (load_main) begin
            if (skid_vld_p0) begin
                addr_p1 <= skid_addr_p0;
                data_p1 <= skid_data_p0;
                corr_p1 <= skid_corr_p0;
                due_p1  <= skid_due_p0;
            end else if (accept) begin
                addr_p1 <= in_addr;
                data_p1 <= in_message;
                corr_p1 <= in_corr;
                due_p1  <= in_due;
            end
        end
    end

    assign out_valid     = vld_p1;
    assign out_addr      = addr_p1;
    assign out_data      = data_p1;
    assign out_corrected = corr_p1;
    assign out_poison    = due_p1;

    assign scrub_push    = accept && in_corr;
    // When full, scrub_valid is necessarily high, so only scrub_ready decides the pass-through.
    assign scrub_dropped = scrub_push && scrub_full && !scrub_ready;
    assign scrub_valid   = !scrub_empty;

    scc_8lc_scrub_fifo #(
        .W     (ADDR_W),
        .DEPTH (SCRUB_DEPTH)
    ) u_scrub_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (scrub_push),
        .push_data (in_addr),
        .pop       (scrub_ready),
        .full      (scrub_full),
        .empty     (scrub_empty),
        .head      (scrub_addr)
    );

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            ce_count   <= '0;
            due_count  <= '0;
            scrub_drop <= '0;
        end else begin
            if (accept && in_corr) begin
                ce_count <= sat_inc(ce_count);
            end
            if (accept && in_due) begin
                due_count <= sat_inc(due_count);
            end
            if (scrub_dropped) begin
                scrub_drop <= sat_inc(scrub_drop);
            end
        end
    end

endmodule

// File: tb/tb_scc_8lc_read_resp_stage.sv
// Bench for scc_8lc_read_resp_stage: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_scc_8lc_read_resp_stage;

    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [63:0]       in_message;
    logic [2:0]        in_error_type;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [63:0]       out_data;
    logic              out_corrected;
    logic              out_poison;
    logic              scrub_valid;
    logic              scrub_ready;
    logic [ADDR_W-1:0] scrub_addr;
    logic              cnt_clr;
    logic [CNT_W-1:0]  ce_count;
    logic [CNT_W-1:0]  due_count;
    logic [CNT_W-1:0]  scrub_drop;

    always #5 clk = ~clk;

    scc_8lc_read_resp_stage #(
        .ADDR_W      (ADDR_W),
        .SCRUB_DEPTH (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_message    (in_message),
        .in_error_type (in_error_type),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .out_poison    (out_poison),
        .scrub_valid   (scrub_valid),
        .scrub_ready   (scrub_ready),
        .scrub_addr    (scrub_addr),
        .cnt_clr       (cnt_clr),
        .ce_count      (ce_count),
        .due_count     (due_count),
        .scrub_drop    (scrub_drop)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference model: beats held by the stage (at most two), pending scrub addresses, counters.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
        logic              corr;
        logic              pois;
    } beat_t;

    beat_t             held_q[$];
    logic [ADDR_W-1:0] scrub_q[$];
    int                m_ce;
    int                m_due;
    int                m_drop;
    int                m_out_cnt;
    bit                m_acc;
    bit                m_spop;
    beat_t             m_beat;

    always @(posedge clk) begin
        if (rst) begin
            held_q.delete();
            scrub_q.delete();
            m_ce   = 0;
            m_due  = 0;
            m_drop = 0;
        end else begin
            m_acc  = in_valid && (held_q.size() < 2);
            m_spop = scrub_ready && (scrub_q.size() > 0);
            if (out_ready && held_q.size() > 0) begin
                void'(held_q.pop_front());
                m_out_cnt++;
            end
            m_beat.addr = in_addr;
            m_beat.data = in_message;
            m_beat.corr = (in_error_type >= 3'd1) && (in_error_type <= 3'd4);
            m_beat.pois = (in_error_type >= 3'd5);
            if (m_spop) void'(scrub_q.pop_front());
            if (m_acc) begin
                held_q.push_back(m_beat);
                if (m_beat.corr) begin
                    if (scrub_q.size() < DEPTH) scrub_q.push_back(in_addr);
                    else if (!cnt_clr) m_drop = (m_drop < CNT_MAX) ? m_drop + 1 : m_drop;
                end
            end
            if (cnt_clr) begin
                m_ce   = 0;
                m_due  = 0;
                m_drop = 0;
            end else if (m_acc) begin
                if (m_beat.corr && m_ce < CNT_MAX) m_ce++;
                if (m_beat.pois && m_due < CNT_MAX) m_due++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", in_ready, held_q.size() < 2);
            chk("m_out_valid", out_valid, held_q.size() > 0);
            if (held_q.size() > 0) begin
                chk("m_out_addr", out_addr, held_q[0].addr);
                chk("m_out_data", out_data, held_q[0].data);
                chk("m_out_corrected", out_corrected, held_q[0].corr);
                chk("m_out_poison", out_poison, held_q[0].pois);
            end
            chk("m_scrub_valid", scrub_valid, scrub_q.size() > 0);
            if (scrub_q.size() > 0) chk("m_scrub_addr", scrub_addr, scrub_q[0]);
            chk("m_ce_count", ce_count, m_ce);
            chk("m_due_count", due_count, m_due);
            chk("m_scrub_drop", scrub_drop, m_drop);
        end
    end

    task automatic send(input logic [ADDR_W-1:0] a, input logic [2:0] et);
        in_valid      = 1'b1;
        in_addr       = a;
        in_message    = {$urandom, $urandom};
        in_error_type = et;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] et;
        logic       corr;
        logic       pois;
    } vec_t;

    vec_t tbl[8];
    int   idx;
    bit   rdy_at_present;

    initial begin
        tbl[0] = '{3'd0, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 1'b1, 1'b0};
        tbl[2] = '{3'd2, 1'b1, 1'b0};
        tbl[3] = '{3'd3, 1'b1, 1'b0};
        tbl[4] = '{3'd4, 1'b1, 1'b0};
        tbl[5] = '{3'd5, 1'b0, 1'b1};
        tbl[6] = '{3'd6, 1'b0, 1'b1};
        tbl[7] = '{3'd7, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b1; in_addr = '0; in_message = '0; in_error_type = 3'd1;
        out_ready = 1'b1; scrub_ready = 1'b1; cnt_clr = 1'b0; m_out_cnt = 0;

        // Reset held three cycles with a corrected beat offered.
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_scrub_valid", scrub_valid, 1'b0);
        chk("rst_ce", ce_count, 0);
        chk("rst_due", due_count, 0);
        chk("rst_drop", scrub_drop, 0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        // Streaming clean beats, one-cycle latency.
        for (int i = 0; i < 16; i++) begin
            send(32'h100 + i, 3'd0);
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_addr", out_addr, 32'h100 + i);
            chk("stream_flags", {out_corrected, out_poison}, 2'b00);
        end

        // Error-class table.
        for (int i = 0; i < 8; i++) begin
            send(32'h300 + i, tbl[i].et);
            chk("tbl_corrected", out_corrected, tbl[i].corr);
            chk("tbl_poison", out_poison, tbl[i].pois);
        end

        // Backpressure: out_ready low for 5 cycles while beats keep arriving.
        idx = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (cyc >= 6 && cyc <= 8) begin
                chk("bp_in_ready_low", in_ready, 1'b0);
                chk("bp_out_stable", out_addr, 32'h400 + 3);
            end
            in_valid = (idx < 12);
            in_addr = 32'h400 + idx;
            in_message = {32'h0, 32'h400 + idx};
            in_error_type = 3'd0;
            rdy_at_present = in_ready;
            @(negedge clk);
            if (in_valid && rdy_at_present) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_all_sent", idx, 12);
        chk("bp_drained", out_valid, 1'b0);

        // Scrub queueing with the write path stalled.
        do_reset();
        scrub_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h10 + i, 3'(i + 1));
        chk("scrub_poison", out_poison, 1'b1);
        chk("scrub_poison_addr", out_addr, 32'h14);
        chk("scrub_ce", ce_count, 4);
        chk("scrub_due", due_count, 1);
        for (int k = 0; k < 4; k++) begin
            chk("scrub_head_valid", scrub_valid, 1'b1);
            chk("scrub_head_addr", scrub_addr, 32'h10 + k);
            scrub_ready = 1'b1;
            @(negedge clk);
        end
        chk("scrub_empty", scrub_valid, 1'b0);

        // Overflow, then push at full with a coincident pop.
        do_reset();
        scrub_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) send(32'h200 + i, 3'd1);
        chk("ovf_drop", scrub_drop, 2);
        scrub_ready = 1'b1;
        send(32'h2f0, 3'd1);
        scrub_ready = 1'b0;
        chk("ovf_passthru_drop", scrub_drop, 2);
        chk("ovf_passthru_head", scrub_addr, 32'h201);
        scrub_ready = 1'b1;

        // Counter saturation and clear priority.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) send(32'h500 + i, 3'd1);
        chk("cnt_sat", ce_count, CNT_MAX);
        cnt_clr = 1'b1;
        send(32'h520, 3'd1);
        cnt_clr = 1'b0;
        chk("cnt_clr_prio", ce_count, 0);
        send(32'h521, 3'd1);
        chk("cnt_after_clr", ce_count, 1);

        // Randomized traffic, including a mid-stream reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst           = (cyc >= 1500 && cyc < 1502);
            in_valid      = ($urandom_range(3, 0) != 0);
            in_addr       = $urandom;
            in_message    = {$urandom, $urandom};
            in_error_type = 3'($urandom_range(7, 0));
            out_ready     = ($urandom_range(2, 0) != 0);
            scrub_ready   = ($urandom_range(3, 0) == 0);
            cnt_clr       = ($urandom_range(49, 0) == 0);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1; scrub_ready = 1'b1;
        repeat (DEPTH + 4) @(negedge clk);
        chk("final_out_idle", out_valid, 1'b0);
        chk("final_scrub_idle", scrub_valid, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
